memory_stage: RTL

Fourth stage of the 5-stage ARM7 pipeline, directly downstream of the execute stage. Consumes the EX/MEM pipeline register and performs load/store accesses on a request/ready data-memory bus. Stalls the upstream pipeline while an access waits, abandons accesses that exceed a timeout, and produces the MEM/WB pipeline register plus the MEM-stage forwarding value.

---
 rtl/mem_stage_pkg.sv | 15 +
 rtl/mem_access_fsm.sv | 84 ++++++++
 rtl/memory_stage.sv | 83 ++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the ARM7 memory stage: FSM states, default
// timeout and the field values that make up a MEM/WB bubble.
package mem_stage_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_e;

   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

   localparam int unsigned BUBBLE_RD        = 0;
   localparam logic        BUBBLE_REG_WRITE = 1'b0;

endpackage

// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer: tracks wait cycles for an outstanding request,
// raises abort_now on timeout or on a rejected access, and drives the stall.
module mem_access_fsm
   import mem_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic access,
   input  logic misaligned,
   input  logic dmem_ready,
   output logic req_ok,
   output logic abort_now,
   output logic mem_stall
);

   localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

   mem_state_e       state, next_state;
   logic [CNT_W-1:0] wait_cnt, next_cnt;
   logic             timeout;

   // wait_cnt is 0 whenever the FSM is in IDLE, so one compare covers both
   // the TIMEOUT_CYCLES == 1 case in IDLE and the normal case in WAIT.
   assign timeout = (wait_cnt == LAST_CNT);

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      next_state = state;
      next_cnt   = wait_cnt;
      abort_now  = 1'b0;
      if (access && misaligned) begin
         abort_now  = 1'b1;
         next_state = IDLE;
         next_cnt   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (access && !dmem_ready) begin
                  if (timeout) begin
                     abort_now = 1'b1;
                  end else begin
                     next_state = WAIT;
                     next_cnt   = CNT_W'(1);
                  end
               end
            end
            WAIT: begin
               if (!access || dmem_ready) begin
                  next_state = IDLE;
                  next_cnt   = '0;
               end else if (timeout) begin
                  abort_now  = 1'b1;
                  next_state = IDLE;
                  next_cnt   = '0;
               end else begin
                  next_cnt = wait_cnt + CNT_W'(1);
               end
            end
            default: begin
               next_state = IDLE;
               next_cnt   = '0;
            end
         endcase
      end
   end

   assign req_ok    = !misaligned;
   assign mem_stall = access && !dmem_ready && !abort_now;

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= next_state;
         wait_cnt <= next_cnt;
      end
   end

endmodule

// File: rtl/memory_stage.sv
// ARM7 pipeline MEM stage: data-memory bus muxing and the MEM/WB register.
// Optional MEM_STAGE_ALIGN_CHECK_EN rejects word-misaligned accesses with an abort.
module memory_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned REG_ADDR_WIDTH = 4,
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_WIDTH-1:0]     ex_mem_alu_result,
   input  logic [DATA_WIDTH-1:0]     ex_mem_write_data,
   input  logic [REG_ADDR_WIDTH-1:0] ex_mem_rd,
   input  logic                      ex_mem_reg_write,
   input  logic                      ex_mem_mem_read,
   input  logic                      ex_mem_mem_write,
   output logic                      dmem_req,
   output logic                      dmem_we,
   output logic [DATA_WIDTH-1:0]     dmem_addr,
   output logic [DATA_WIDTH-1:0]     dmem_wdata,
   input  logic [DATA_WIDTH-1:0]     dmem_rdata,
   input  logic                      dmem_ready,
   output logic                      mem_stall,
   output logic [DATA_WIDTH-1:0]     mem_forward_data,
   output logic [DATA_WIDTH-1:0]     mem_wb_result,
   output logic [REG_ADDR_WIDTH-1:0] mem_wb_rd,
   output logic                      mem_wb_reg_write,
   output logic                      data_abort
);

   logic access, misaligned, req_ok, abort_now, fsm_stall;

   assign access = ex_mem_mem_read | ex_mem_mem_write;

`ifdef MEM_STAGE_ALIGN_CHECK_EN
   assign misaligned = (ex_mem_alu_result[1:0] != 2'b00);
   assign dmem_addr  = ex_mem_alu_result;
`else
   assign misaligned = 1'b0;
   assign dmem_addr  = {ex_mem_alu_result[DATA_WIDTH-1:2], 2'b00};
`endif

   mem_access_fsm #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_fsm (
      .clk       (clk),
      .rst       (rst),
      .access    (access),
      .misaligned(misaligned),
      .dmem_ready(dmem_ready),
      .req_ok    (req_ok),
      .abort_now (abort_now),
      .mem_stall (fsm_stall)
   );

   // Reset kills the bus request and stall immediately, even mid-access.
   assign dmem_req         = access && req_ok && !rst;
   assign mem_stall        = fsm_stall && !rst;
   assign dmem_we          = ex_mem_mem_write && !ex_mem_mem_read;
   assign dmem_wdata       = ex_mem_write_data;
   assign mem_forward_data = ex_mem_alu_result;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_wb_result    <= '0;
         mem_wb_rd        <= '0;
         mem_wb_reg_write <= 1'b0;
         data_abort       <= 1'b0;
      end else begin
         data_abort <= abort_now;
         if (fsm_stall || abort_now) begin
            mem_wb_rd        <= REG_ADDR_WIDTH'(BUBBLE_RD);
            mem_wb_reg_write <= BUBBLE_REG_WRITE;
         end else begin
            mem_wb_result    <= ex_mem_mem_read ? dmem_rdata : ex_mem_alu_result;
            mem_wb_rd        <= ex_mem_rd;
            mem_wb_reg_write <= ex_mem_reg_write && !ex_mem_mem_write;
         end
      end
   end

endmodule
